// File: rtl/bcd_a_segundos_pkg.sv
// Shared definitions for the BCD-seconds to binary decoder: FSM encoding,
// iteration count, valid BCD range and the input validity rule.
package bcd_a_segundos_pkg;

    localparam int         ITER    = 7;
    localparam logic [7:0] MAX_BCD = 8'h59;
    localparam logic [7:0] MIN_BCD = 8'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Each digit is bounded by the matching digit of MAX_BCD (tens <= 5, units <= 9).
    function automatic logic bcd_is_valid(input logic [7:0] value);
        return (value[3:0] <= MAX_BCD[3:0]) &&
               (value[7:4] <= MAX_BCD[7:4]) &&
               (value >= MIN_BCD);
    endfunction

endpackage

// File: rtl/bcd_a_segundos_if.sv
// Request/result bundle of the BCD-seconds decoder; master drives the
// request side, slave (the decoder) drives the registered results.
interface bcd_a_segundos_if;

    logic       EN;
    logic       start;
    logic [7:0] bcd_in;
    logic [5:0] binary_out;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output EN, start, bcd_in,
        input  binary_out, busy, done, error
    );

    modport slave (
        input  EN, start, bcd_in,
        output binary_out, busy, done, error
    );

endinterface

// File: rtl/bcd_nibble_corr.sv
// Reverse double-dabble digit correction: a BCD nibble that reached 8 or
// more after the right shift gets 3 subtracted.
module bcd_nibble_corr (
    input  logic [3:0] nibble,
    output logic [3:0] corrected
);

    always_comb begin
        corrected = (nibble >= 4'd8) ? (nibble - 4'd3) : nibble;
    end

endmodule

// File: rtl/bcd_a_segundos.sv
// Converts a packed 2-digit BCD seconds value (01..59) into binary minus one
// using an iterative reverse double-dabble, with all outputs registered.
module bcd_a_segundos #(
    parameter int ITER = bcd_a_segundos_pkg::ITER
) (
    input  logic             clk,
    input  logic             reset,
    bcd_a_segundos_if.slave  bus
);

    import bcd_a_segundos_pkg::*;

    localparam int               CNT_W     = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       bcd_q;
    logic [14:0]      scratch;
    logic [CNT_W-1:0] cnt;
    logic [14:0]      shifted;
    logic [14:0]      corrected;
    logic [3:0]       hi_corr;
    logic [3:0]       lo_corr;
    logic             accept;
    logic             input_ok;
    logic             last_iter;

    logic [5:0]       binary_q, binary_next;
    logic             error_q, error_next;
    logic             busy_q, busy_next;
    logic             done_q, done_next;

    assign shifted   = {1'b0, scratch[14:1]};
    assign corrected = {hi_corr, lo_corr, shifted[6:0]};
    assign accept    = (state == IDLE) && bus.EN && bus.start;
    assign input_ok  = bcd_is_valid(bcd_q);
    assign last_iter = (cnt == LAST_ITER);

    bcd_nibble_corr u_corr_hi (.nibble(shifted[14:11]), .corrected(hi_corr));
    bcd_nibble_corr u_corr_lo (.nibble(shifted[10:7]),  .corrected(lo_corr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            binary_q <= '0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            binary_q <= binary_next;
            error_q  <= error_next;
            busy_q   <= busy_next;
            done_q   <= done_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q   <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                bcd_q <= bus.bcd_in;
            end
            if (state == CHECK) begin
                scratch <= {bcd_q, 7'b0};
                cnt     <= '0;
            end else if (state == CONVERT) begin
                scratch <= corrected;
                cnt     <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CHECK;
            CHECK:   if (!bus.EN) state_next = IDLE;
                     else         state_next = input_ok ? CONVERT : DONE;
            CONVERT: if (!bus.EN)      state_next = IDLE;
                     else if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; an EN drop outside IDLE zeroes the results.
    always_comb begin
        binary_next = binary_q;
        error_next  = error_q;
        busy_next   = (state_next != IDLE);
        done_next   = (state_next == DONE);
        if (accept) begin
            error_next = 1'b0;
        end else if (state != IDLE && !bus.EN) begin
            binary_next = '0;
            error_next  = 1'b0;
        end else if (state == CHECK && !input_ok) begin
            binary_next = '0;
            error_next  = 1'b1;
        end else if (state == CONVERT && last_iter) begin
            binary_next = 6'(corrected[6:0] - 7'd1);
            error_next  = 1'b0;
        end
    end

    assign bus.binary_out = binary_q;
    assign bus.error      = error_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: doc/bcd_a_segundos.md
BCD_A_SEGUNDOS -- requirements
Module: bcd_a_segundos

Interface
REQ-001 SHALL have parameter ITER, default 7, meaning the number of reverse-double-dabble iterations (fixed by the 2-digit BCD width).
REQ-002 SHALL have port clk  in  1  system clock, rising-edge active.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port EN  in  1  block enable; low aborts any operation and blocks start.
REQ-005 SHALL have port start  in  1  single-cycle request to convert bcd_in.
REQ-006 SHALL have port bcd_in  in  8  packed BCD seconds (tens in [7:4], units in [3:0]), valid range 8'h01..8'h59.
REQ-007 SHALL have port binary_out  out  6  registered result, equal to BCD value minus 1 (0..58).
REQ-008 SHALL have port busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port error  out  1  registered flag, high when the last captured input was invalid.

Function
REQ-011 SHALL implement the exact inverse of the seconds BCD encoder: bcd_in 8'h01 maps to 6'd0, and bcd_in 8'h59 maps to 6'd58.
REQ-012 SHALL use FSM states IDLE, CHECK, CONVERT, DONE.
REQ-013 SHALL, in IDLE, capture bcd_in at a clock edge where start=1 and EN=1, then move to CHECK; start is ignored in every other state.
REQ-014 SHALL treat the input as invalid in CHECK if units>9, tens>5, or value==8'h00; invalid input goes to DONE with error=1 and binary_out=0.
REQ-015 SHALL, for valid input, go from CHECK to CONVERT, load scratch={bcd,7'b0}, and clear the iteration counter.
REQ-016 SHALL, for each CONVERT edge, shift scratch right by 1 and then subtract 3 from each BCD nibble that is >=8.
REQ-017 SHALL, after the ITER-th iteration, register binary_out=scratch[6:0]-1 (truncated to 6 bits) and error=0, then go to DONE.
REQ-018 SHALL make latency for a valid input equal to the start edge N, with done high in the cycle after edge N+8; for an invalid input, done is high in the cycle after edge N+1.
REQ-019 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE unconditionally.
REQ-020 SHALL hold binary_out and error from DONE until the next accepted start; a new accepted start clears error.
REQ-021 SHALL, on EN=0 in any non-IDLE state, return to IDLE at the next edge with binary_out=0, error=0, and no done pulse.
REQ-022 SHALL, when start and EN drop are simultaneous in IDLE, accept no request.

Reset
REQ-023 SHALL, on reset low, force state=IDLE, binary_out=0, busy=0, done=0, error=0, and counter=0 immediately, independent of clk.
REQ-024 SHALL discard any in-flight conversion on reset assertion mid-operation and produce no done pulse after release.

Structure
REQ-025 SHALL place in a shared package: state encoding, ITER=7, MAX_BCD=8'h59, MIN_BCD=8'h01.
REQ-026 SHALL implement the per-nibble correction (subtract 3 if >=8) as one combinational sub-module, bcd_nibble_corr, instantiated twice.
REQ-027 SHALL register all outputs; no combinational path from bcd_in to any output.

Verification
REQ-028 SHALL verify: bcd_in=8'h01, start at edge N -> done in the cycle after N+8, binary_out=0, error=0.
REQ-029 SHALL verify: bcd_in=8'h59 -> binary_out=58, error=0; bcd_in=8'h30 -> binary_out=29.
REQ-030 SHALL verify: bcd_in=8'h5A, 8'h60, and 8'h00 each -> done in the cycle after N+1, error=1, binary_out=0.
REQ-031 SHALL verify: second start pulse with bcd_in=8'h10 during CONVERT of 8'h25 -> ignored; result binary_out=24.
REQ-032 SHALL verify: EN dropped at edge N+4 -> no done, outputs 0, busy low after the next edge.
REQ-033 SHALL verify: reset pulsed low mid-CONVERT -> all outputs 0 asynchronously; a subsequent 8'h12 conversion yields binary_out=11.
